// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : Parametrised register file with one synchronous write port,
//             two combinational read ports and a per-register pending-write
//             scoreboard (decode reserves, writeback releases).
//  Options  : REGFILE_BYPASS_EN - write-through forwarding on the read ports
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              RESERVE,
  input  logic [ADDR_W-1:0] RSVADDRESS,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              RSV_STALL,
  output logic [ADDR_W:0]   PENDING_CNT
);

  localparam int              c_depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic            c_zero_reg = (ZERO_REG != 0);

  logic [DATA_W-1:0]  r_regs [c_depth];
  logic [c_depth-1:0] r_pending;
  logic [ADDR_W:0]    r_pending_cnt;

  logic               w_wr_en;
  logic               w_wr_hits_rsv;
  logic               w_rsv_acc;
  logic               w_cnt_inc;
  logic               w_cnt_dec;
  logic [c_depth-1:0] w_pending_nxt;
  logic [DATA_W-1:0]  w_out1;
  logic [DATA_W-1:0]  w_out2;
  logic               w_busy1;
  logic               w_busy2;

  // Writes to a hardwired-zero r0 are dropped entirely.
  assign w_wr_en       = WRITE & ~(c_zero_reg & (INADDRESS == '0));
  assign w_wr_hits_rsv = WRITE & (INADDRESS == RSVADDRESS);

  // A pending register can only be re-reserved when its producer writes back
  // in the same cycle; otherwise decode must hold and retry.
  assign RSV_STALL = RESERVE & r_pending[RSVADDRESS] & ~w_wr_hits_rsv;

  // Reserving r0 in zero-register mode is accepted but has no effect.
  assign w_rsv_acc = RESERVE & ~RSV_STALL & ~(c_zero_reg & (RSVADDRESS == '0));

  // Count tracks popcount: a reserve only adds when the bit was clear, and a
  // release is cancelled when a reserve re-sets the same bit in that cycle.
  assign w_cnt_inc = w_rsv_acc & ~r_pending[RSVADDRESS];
  assign w_cnt_dec = w_wr_en & r_pending[INADDRESS] &
                     ~(w_rsv_acc & (RSVADDRESS == INADDRESS));

  // Next pending vector: release first so a same-register reserve wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wr_en) begin
      w_pending_nxt[INADDRESS] = 1'b0;
    end
    if (w_rsv_acc) begin
      w_pending_nxt[RSVADDRESS] = 1'b1;
    end
    if (c_zero_reg) begin
      w_pending_nxt[0] = 1'b0;
    end
  end

  // Register array, scoreboard and pending counter update.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < c_depth; i++) begin
        r_regs[i] <= '0;
      end
      r_pending     <= '0;
      r_pending_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[INADDRESS] <= IN;
      end
      r_pending <= w_pending_nxt;
      if (w_cnt_inc && !w_cnt_dec) begin
        r_pending_cnt <= r_pending_cnt + c_cnt_one;
      end else if (w_cnt_dec && !w_cnt_inc) begin
        r_pending_cnt <= r_pending_cnt - c_cnt_one;
      end
    end
  end

  // Read ports: stored data and pending state, with optional forwarding.
  always_comb begin
    w_out1  = r_regs[OUT1ADDRESS];
    w_out2  = r_regs[OUT2ADDRESS];
    w_busy1 = r_pending[OUT1ADDRESS];
    w_busy2 = r_pending[OUT2ADDRESS];
    if (c_zero_reg && (OUT1ADDRESS == '0)) begin
      w_out1 = '0;
    end
    if (c_zero_reg && (OUT2ADDRESS == '0)) begin
      w_out2 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (!RESET && w_wr_en && (INADDRESS == OUT1ADDRESS)) begin
      w_out1  = IN;
      w_busy1 = 1'b0;
    end
    if (!RESET && w_wr_en && (INADDRESS == OUT2ADDRESS)) begin
      w_out2  = IN;
      w_busy2 = 1'b0;
    end
`endif
  end

  assign OUT1        = w_out1;
  assign OUT2        = w_out2;
  assign BUSY1       = w_busy1;
  assign BUSY2       = w_busy2;
  assign PENDING_CNT = r_pending_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Purpose  : Self-checking bench for reg_file_sb. Two instances (ZERO_REG=0
//             and ZERO_REG=1) share the stimulus and are compared against an
//             array/popcount reference model. Honours REGFILE_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  logic       CLOCK;
  logic       RESET;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic       RESERVE;
  logic [2:0] RSVADDRESS;

  logic [7:0] out1 [2];
  logic [7:0] out2 [2];
  logic       busy1 [2];
  logic       busy2 [2];
  logic       stall [2];
  logic [3:0] cnt   [2];

  int checks = 0;
  int errors = 0;

  // Reference model: register contents and pending flags per instance.
  logic [7:0] m_regs [2][8];
  bit         m_pend [2][8];

  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) u_dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS),
    .IN(IN), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(out1[0]), .OUT2(out2[0]), .RESERVE(RESERVE),
    .RSVADDRESS(RSVADDRESS), .BUSY1(busy1[0]), .BUSY2(busy2[0]),
    .RSV_STALL(stall[0]), .PENDING_CNT(cnt[0])
  );

  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) u_dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS),
    .IN(IN), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(out1[1]), .OUT2(out2[1]), .RESERVE(RESERVE),
    .RSVADDRESS(RSVADDRESS), .BUSY1(busy1[1]), .BUSY2(busy2[1]),
    .RSV_STALL(stall[1]), .PENDING_CNT(cnt[1])
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  function automatic bit fwd(int z, logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
    return !RESET && WRITE && (INADDRESS == a) && !(z == 1 && a == 3'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_out(int z, logic [2:0] a);
    if (fwd(z, a)) return IN;
    if (z == 1 && a == 3'd0) return 8'h00;
    return m_regs[z][a];
  endfunction

  function automatic logic exp_busy(int z, logic [2:0] a);
    if (fwd(z, a)) return 1'b0;
    return m_pend[z][a];
  endfunction

  function automatic logic exp_stall(int z);
    return RESERVE && m_pend[z][RSVADDRESS] &&
           !(WRITE && INADDRESS == RSVADDRESS);
  endfunction

  function automatic logic [3:0] exp_cnt(int z);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_pend[z][i]);
    return 4'(n);
  endfunction

  task automatic chk(string tag, int z, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, z, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int z = 0; z < 2; z++) begin
      chk("out1",  z, 32'(out1[z]),  32'(exp_out(z, OUT1ADDRESS)));
      chk("out2",  z, 32'(out2[z]),  32'(exp_out(z, OUT2ADDRESS)));
      chk("busy1", z, 32'(busy1[z]), 32'(exp_busy(z, OUT1ADDRESS)));
      chk("busy2", z, 32'(busy2[z]), 32'(exp_busy(z, OUT2ADDRESS)));
      chk("stall", z, 32'(stall[z]), 32'(exp_stall(z)));
      chk("count", z, 32'(cnt[z]),   32'(exp_cnt(z)));
    end
  endtask

  // Inputs are stable across the edge, so the model can be advanced just
  // after it using the same input values the DUT sampled.
  task automatic model_update();
    for (int z = 0; z < 2; z++) begin
      bit st = exp_stall(z);
      if (RESET) begin
        for (int i = 0; i < 8; i++) begin
          m_regs[z][i] = 8'h00;
          m_pend[z][i] = 1'b0;
        end
      end else begin
        if (WRITE && !(z == 1 && INADDRESS == 3'd0)) begin
          m_regs[z][INADDRESS] = IN;
          m_pend[z][INADDRESS] = 1'b0;
        end
        if (RESERVE && !st && !(z == 1 && RSVADDRESS == 3'd0))
          m_pend[z][RSVADDRESS] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge CLOCK);
    model_update();
    #1;
  endtask

  task automatic idle();
    RESET = 0; WRITE = 0; RESERVE = 0;
  endtask

  initial begin
    RESET = 1; WRITE = 0; RESERVE = 0;
    INADDRESS = 0; IN = 0; OUT1ADDRESS = 0; OUT2ADDRESS = 0; RSVADDRESS = 0;
    repeat (2) @(posedge CLOCK);
    model_update();
    #1;

    // Reset state.
    idle();
    OUT1ADDRESS = 3; OUT2ADDRESS = 6;
    tick();

    // Reset clears a written register.
    WRITE = 1; INADDRESS = 3; IN = 8'hA5;
    tick();
    idle();
    #1 chk("wr_a5", 0, 32'(out1[0]), 32'h0A5);
    RESET = 1;
    tick();
    idle();
    #1;
    chk("rst_out1", 0, 32'(out1[0]), 32'h0);
    chk("rst_cnt",  0, 32'(cnt[0]),  32'h0);
    chk("rst_busy", 0, 32'(busy1[0]), 32'h0);

    // Reserve / release r5.
    RESERVE = 1; RSVADDRESS = 5;
    tick();
    idle(); OUT1ADDRESS = 5;
    #1;
    chk("rsv_busy", 0, 32'(busy1[0]), 32'h1);
    chk("rsv_cnt",  0, 32'(cnt[0]),   32'h1);
    WRITE = 1; INADDRESS = 5; IN = 8'h3C;
    tick();
    idle();
    #1;
    chk("rel_out1", 0, 32'(out1[0]),  32'h3C);
    chk("rel_busy", 0, 32'(busy1[0]), 32'h0);
    chk("rel_cnt",  0, 32'(cnt[0]),   32'h0);

    // Reserve stall on pending r2, then release and re-reserve together.
    RESERVE = 1; RSVADDRESS = 2;
    tick();
    #1 chk("stall_hi", 0, 32'(stall[0]), 32'h1);
    tick();
    chk("stall_cnt", 0, 32'(cnt[0]), 32'h1);
    WRITE = 1; INADDRESS = 2; IN = 8'h11;
    #1 chk("stall_lo", 0, 32'(stall[0]), 32'h0);
    tick();
    idle(); OUT1ADDRESS = 2;
    #1;
    chk("rr_out1", 0, 32'(out1[0]),  32'h11);
    chk("rr_busy", 0, 32'(busy1[0]), 32'h1);
    chk("rr_cnt",  0, 32'(cnt[0]),   32'h1);

    // Counter full range.
    RESET = 1;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      RESERVE = 1; RSVADDRESS = 3'(i);
      tick();
    end
    idle();
    #1;
    chk("full_cnt", 0, 32'(cnt[0]), 32'h8);
    chk("full_cnt", 1, 32'(cnt[1]), 32'h7);
    for (int i = 0; i < 8; i++) begin
      WRITE = 1; INADDRESS = 3'(i); IN = 8'(8'h40 + i);
      tick();
    end
    idle();
    #1;
    chk("empty_cnt", 0, 32'(cnt[0]), 32'h0);
    chk("empty_cnt", 1, 32'(cnt[1]), 32'h0);

    // Zero register: write and reserve r0.
    WRITE = 1; INADDRESS = 0; IN = 8'hFF;
    RESERVE = 1; RSVADDRESS = 0; OUT1ADDRESS = 0;
    #1 chk("z_stall", 1, 32'(stall[1]), 32'h0);
    tick();
    idle();
    #1;
    chk("z_out1", 1, 32'(out1[1]),  32'h0);
    chk("z_busy", 1, 32'(busy1[1]), 32'h0);
    chk("z_cnt",  1, 32'(cnt[1]),   32'h0);

    // Forwarding (or not) on port 2 for a pending r4.
    WRITE = 1; INADDRESS = 4; IN = 8'h22;
    tick();
    idle(); RESERVE = 1; RSVADDRESS = 4;
    tick();
    idle(); WRITE = 1; INADDRESS = 4; IN = 8'h77; OUT2ADDRESS = 4;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_out2", 0, 32'(out2[0]),  32'h77);
    chk("byp_busy", 0, 32'(busy2[0]), 32'h0);
`else
    chk("byp_out2", 0, 32'(out2[0]),  32'h22);
    chk("byp_busy", 0, 32'(busy2[0]), 32'h1);
`endif
    tick();
    idle();

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      RESET       = ($urandom_range(0, 39) == 0);
      WRITE       = $urandom_range(0, 1) == 1;
      INADDRESS   = 3'($urandom_range(0, 7));
      IN          = 8'($urandom);
      RESERVE     = $urandom_range(0, 2) != 0;
      RSVADDRESS  = 3'($urandom_range(0, 7));
      OUT1ADDRESS = ($urandom_range(0, 3) == 0) ? INADDRESS : 3'($urandom_range(0, 7));
      OUT2ADDRESS = ($urandom_range(0, 3) == 0) ? RSVADDRESS : 3'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file for the pipelined CPU datapath.
- One synchronous write port and two combinational read ports.
- Per-register pending-write scoreboard. Decode reserves a destination register. Writeback releases it by writing. Operand reads report when their register is still awaiting a result.
- Sits between decode (read/reserve) and writeback (write). Replaces the fixed 8x8 register file.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, address width; depth = 2**ADDR_W registers
ZERO_REG, 0, when 1 register 0 is hardwired to zero: reads return 0, writes and reserves to it are ignored

Ports:
CLOCK  input  1  clock; all state updates on rising edge
RESET  input  1  reset, synchronous, active-high
WRITE  input  1  write enable (writeback)
INADDRESS  input  ADDR_W  write register number
IN  input  DATA_W  write data
OUT1ADDRESS  input  ADDR_W  read port 1 register number
OUT2ADDRESS  input  ADDR_W  read port 2 register number
OUT1  output  DATA_W  read port 1 data
OUT2  output  DATA_W  read port 2 data
RESERVE  input  1  request to mark RSVADDRESS pending (decode)
RSVADDRESS  input  ADDR_W  register to reserve
BUSY1  output  1  register at OUT1ADDRESS has a pending write
BUSY2  output  1  register at OUT2ADDRESS has a pending write
RSV_STALL  output  1  reservation refused this cycle
PENDING_CNT  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset: on a rising edge with RESET=1, all registers, all pending bits and PENDING_CNT go to 0. RESET dominates WRITE and RESERVE in the same cycle. After reset, OUT1/OUT2 read 0 and BUSY1, BUSY2, RSV_STALL are 0 (given RESERVE=0).
- Reads: OUT1/OUT2 are purely combinational from the register array. No #delays in RTL. Both ports may address the same register.
- Write: on a rising edge with WRITE=1, RESET=0: registers[INADDRESS] <= IN and pending[INADDRESS] <= 0. New data is visible on the read ports after the edge. A write to a non-pending register is legal: data is stored and the count is unchanged.
- Reserve: on a rising edge with RESERVE=1, RESET=0, RSV_STALL=0: pending[RSVADDRESS] <= 1.
- RSV_STALL (combinational) = RESERVE & pending[RSVADDRESS] & ~(WRITE & INADDRESS==RSVADDRESS).
  - A stalled reserve has no effect.
  - Decode holds RESERVE and RSVADDRESS until RSV_STALL drops.
- Simultaneous WRITE and RESERVE to the same address: the write stores the data, the reserve wins, and the pending bit ends at 1 (new producer). PENDING_CNT is unchanged.
- BUSY1 = pending[OUT1ADDRESS]; BUSY2 = pending[OUT2ADDRESS]. Both reflect registered state only.
- PENDING_CNT is a registered counter updated incrementally each edge:
  - +1 for an accepted reserve of a non-pending register.
  - -1 for a write clearing a pending bit.
  - Net 0 when both happen on the same register.
  - It always equals the popcount of the pending bits. Range 0..2**ADDR_W; it never wraps.
- ZERO_REG=1:
  - Register 0 is never written.
  - pending[0] is constantly 0, so BUSY1/BUSY2 are 0 for address 0.
  - A reserve of address 0 is accepted (no stall) but ignored.
  - OUT1/OUT2 read 0 for address 0.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If WRITE=1 and INADDRESS==OUT1ADDRESS, then OUT1=IN and BUSY1=0 in the same cycle; likewise for port 2. Excluded when ZERO_REG=1 and the address is 0. Forwarding is suppressed while RESET=1.
- Not defined: read ports show stored values only. Written data and cleared BUSY appear after the rising edge.

Test Plan:
- Reset: write 0xA5 to r3, then assert RESET one cycle -> OUT1 (addr 3) = 0x00, PENDING_CNT=0, BUSY1=0.
- Reserve/release: reserve r5 -> next cycle BUSY1=1 (OUT1ADDRESS=5), PENDING_CNT=1; write 0x3C to r5 -> after edge OUT1=0x3C, BUSY1=0, PENDING_CNT=0.
- Reserve stall: r2 pending, RESERVE r2 with no write -> RSV_STALL=1 and count stays 1. Same cycle add WRITE r2=0x11 -> RSV_STALL=0; after edge r2=0x11, still pending, count 1.
- Counter full range (ADDR_W=3, ZERO_REG=0): reserve r0..r7 on successive cycles -> PENDING_CNT=8. Write all eight -> 0, no wrap.
- ZERO_REG=1: write 0xFF to r0 and reserve r0 -> OUT1 (addr 0) = 0, BUSY1=0, RSV_STALL=0, PENDING_CNT=0.
- REGFILE_BYPASS_EN: r4 pending, WRITE r4=0x77 with OUT2ADDRESS=4 -> OUT2=0x77 and BUSY2=0 before the edge. Without the macro, OUT2 shows the old value and BUSY2=1 until the edge.
